// File: rtl/leaf_spine_uplink.sv
// Leaf-side end of the leaf-to-spine links: TX sprays local flits round-robin over
// enabled spine uplinks; RX filters, buffers per spine and merges downlinks into one stream.
module leaf_spine_uplink #(
  parameter logic [3:0]  GROUP_ID   = 4'b0110,
  parameter logic [1:0]  LEAF_ID    = 2'd0,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RX_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        spine_en,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] up1_data,
  output logic [DWIDTH-1:0] up2_data,
  output logic [DWIDTH-1:0] up3_data,
  output logic [DWIDTH-1:0] up4_data,
  output logic              up1_valid,
  output logic              up2_valid,
  output logic              up3_valid,
  output logic              up4_valid,
  input  logic [DWIDTH-1:0] dn1_data,
  input  logic [DWIDTH-1:0] dn2_data,
  input  logic [DWIDTH-1:0] dn3_data,
  input  logic [DWIDTH-1:0] dn4_data,
  input  logic              dn1_valid,
  input  logic              dn2_valid,
  input  logic              dn3_valid,
  input  logic              dn4_valid,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        misroute_cnt
);

  localparam int unsigned TXAW = $clog2(FIFO_DEPTH);
  localparam int unsigned RXAW = $clog2(RX_DEPTH);
  localparam logic [TXAW:0] TX_FULL_CNT = (TXAW+1)'(FIFO_DEPTH);
  localparam logic [RXAW:0] RX_FULL_CNT = (RXAW+1)'(RX_DEPTH);

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [2:0] n);
    logic [8:0] s;
    s = {1'b0, c} + {6'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // ---------------- TX path ----------------
  logic [DWIDTH-1:0]        r_tx_mem [FIFO_DEPTH];
  logic [TXAW-1:0]          r_tx_wp;
  logic [TXAW-1:0]          r_tx_rp;
  logic [TXAW:0]            r_tx_cnt;
  logic [1:0]               r_tx_ptr;
  logic                     r_tx_live;
  logic [3:0]               r_up_valid;
  logic [3:0][DWIDTH-1:0]   r_up_data;

  logic                     w_tx_full;
  logic                     w_tx_empty;
  logic                     w_tx_push;
  logic                     w_tx_pop;
  logic [1:0]               w_tx_tgt;
  logic [1:0]               w_tx_idx;
  logic                     w_tx_found;

  assign w_tx_full  = (r_tx_cnt == TX_FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  // r_tx_live keeps tx_ready low while reset is held and until the first edge after release
  assign tx_ready   = r_tx_live && !w_tx_full;
  assign w_tx_push  = tx_valid && tx_ready;
  assign w_tx_pop   = !w_tx_empty && (spine_en != 4'b0000);

  always_comb begin
    w_tx_tgt   = r_tx_ptr;
    w_tx_idx   = r_tx_ptr;
    w_tx_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_tx_idx = r_tx_ptr + 2'(i);
      if (!w_tx_found && spine_en[w_tx_idx]) begin
        w_tx_found = 1'b1;
        w_tx_tgt   = w_tx_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_live  <= 1'b0;
      r_tx_wp    <= '0;
      r_tx_rp    <= '0;
      r_tx_cnt   <= '0;
      r_tx_ptr   <= '0;
      r_up_valid <= '0;
      r_up_data  <= '0;
    end else begin
      r_tx_live <= 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop) begin
        r_tx_rp  <= r_tx_rp + 1'b1;
        r_tx_ptr <= w_tx_tgt + 2'd1;
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_tx_pop && (w_tx_tgt == 2'(i))) begin
          r_up_valid[i] <= 1'b1;
          r_up_data[i]  <= r_tx_mem[r_tx_rp];
        end else begin
          r_up_valid[i] <= 1'b0;
          r_up_data[i]  <= '0;
        end
      end
    end
  end

  assign up1_valid = r_up_valid[0];
  assign up2_valid = r_up_valid[1];
  assign up3_valid = r_up_valid[2];
  assign up4_valid = r_up_valid[3];
  assign up1_data  = r_up_data[0];
  assign up2_data  = r_up_data[1];
  assign up3_data  = r_up_data[2];
  assign up4_data  = r_up_data[3];

  // ---------------- RX path ----------------
  logic [DWIDTH-1:0]        r_rx_mem [4][RX_DEPTH];
  logic [3:0][RXAW-1:0]     r_rx_wp;
  logic [3:0][RXAW-1:0]     r_rx_rp;
  logic [3:0][RXAW:0]       r_rx_cnt;
  logic [1:0]               r_rx_ptr;
  logic [DWIDTH-1:0]        r_rx_data;
  logic                     r_rx_valid;
  logic [7:0]               r_drop_cnt;
  logic [7:0]               r_mis_cnt;

  logic [3:0][DWIDTH-1:0]   w_dn_data;
  logic [3:0]               w_dn_valid;
  logic [3:0]               w_rx_full;
  logic [3:0]               w_rx_empty;
  logic [3:0]               w_rx_push;
  logic [3:0]               w_rx_pop;
  logic [3:0]               w_mis;
  logic [3:0]               w_drop;
  logic [2:0]               w_mis_n;
  logic [2:0]               w_drop_n;
  logic                     w_load;
  logic [1:0]               w_src;
  logic [1:0]               w_src_idx;
  logic                     w_src_found;

  assign w_dn_data  = {dn4_data, dn3_data, dn2_data, dn1_data};
  assign w_dn_valid = {dn4_valid, dn3_valid, dn2_valid, dn1_valid};
  assign w_load     = !r_rx_valid || rx_ready;

  // Fullness comes from the registered count, so a same-cycle pop never makes room for a push
  always_comb begin
    w_mis_n  = '0;
    w_drop_n = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_rx_full[i]  = (r_rx_cnt[i] == RX_FULL_CNT);
      w_rx_empty[i] = (r_rx_cnt[i] == '0);
      w_mis[i]      = w_dn_valid[i] &&
                      ((w_dn_data[i][DWIDTH-1 -: 4] != GROUP_ID) ||
                       (w_dn_data[i][DWIDTH-5 -: 2] != LEAF_ID));
      w_drop[i]     = w_dn_valid[i] && !w_mis[i] && w_rx_full[i];
      w_rx_push[i]  = w_dn_valid[i] && !w_mis[i] && !w_rx_full[i];
      w_mis_n       = w_mis_n + {2'b00, w_mis[i]};
      w_drop_n      = w_drop_n + {2'b00, w_drop[i]};
    end
  end

  always_comb begin
    w_src       = r_rx_ptr;
    w_src_idx   = r_rx_ptr;
    w_src_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_src_idx = r_rx_ptr + 2'(i);
      if (!w_src_found && !w_rx_empty[w_src_idx]) begin
        w_src_found = 1'b1;
        w_src       = w_src_idx;
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      w_rx_pop[i] = w_load && w_src_found && (w_src == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_rx_push[i]) r_rx_mem[i][r_rx_wp[i]] <= w_dn_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_cnt   <= '0;
      r_rx_ptr   <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_drop_cnt <= '0;
      r_mis_cnt  <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_rx_push[i]) r_rx_wp[i] <= r_rx_wp[i] + 1'b1;
        if (w_rx_pop[i])  r_rx_rp[i] <= r_rx_rp[i] + 1'b1;
        case ({w_rx_push[i], w_rx_pop[i]})
          2'b10:   r_rx_cnt[i] <= r_rx_cnt[i] + 1'b1;
          2'b01:   r_rx_cnt[i] <= r_rx_cnt[i] - 1'b1;
          default: r_rx_cnt[i] <= r_rx_cnt[i];
        endcase
      end
      if (w_load) begin
        if (w_src_found) begin
          r_rx_data  <= r_rx_mem[w_src][r_rx_rp[w_src]];
          r_rx_valid <= 1'b1;
          r_rx_ptr   <= w_src + 2'd1;
        end else begin
          r_rx_valid <= 1'b0;
        end
      end
      r_drop_cnt <= sat_add(r_drop_cnt, w_drop_n);
      r_mis_cnt  <= sat_add(r_mis_cnt, w_mis_n);
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign drop_cnt     = r_drop_cnt;
  assign misroute_cnt = r_mis_cnt;

endmodule

// File: tb/tb_leaf_spine_uplink.sv
// Directed bench for leaf_spine_uplink: TX spraying, masking, stall, RX merge/filter,
// overflow drops, counter saturation and asynchronous reset mid-stream.
module tb_leaf_spine_uplink;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  spine_en;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] up1_data, up2_data, up3_data, up4_data;
  logic        up1_valid, up2_valid, up3_valid, up4_valid;
  logic [15:0] dn1_data, dn2_data, dn3_data, dn4_data;
  logic        dn1_valid, dn2_valid, dn3_valid, dn4_valid;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  drop_cnt;
  logic [7:0]  misroute_cnt;

  logic [3:0]  upv;
  logic [63:0] up_all;
  assign upv    = {up4_valid, up3_valid, up2_valid, up1_valid};
  assign up_all = {up4_data, up3_data, up2_data, up1_data};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  leaf_spine_uplink #(
    .GROUP_ID(4'b0110), .LEAF_ID(2'd0), .DWIDTH(16), .FIFO_DEPTH(8), .RX_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .spine_en(spine_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .up1_data(up1_data), .up2_data(up2_data), .up3_data(up3_data), .up4_data(up4_data),
    .up1_valid(up1_valid), .up2_valid(up2_valid), .up3_valid(up3_valid), .up4_valid(up4_valid),
    .dn1_data(dn1_data), .dn2_data(dn2_data), .dn3_data(dn3_data), .dn4_data(dn4_data),
    .dn1_valid(dn1_valid), .dn2_valid(dn2_valid), .dn3_valid(dn3_valid), .dn4_valid(dn4_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dn();
    dn1_valid = 0; dn2_valid = 0; dn3_valid = 0; dn4_valid = 0;
    dn1_data = '0; dn2_data = '0; dn3_data = '0; dn4_data = '0;
  endtask

  task automatic test_reset();
    reset = 0; spine_en = 4'b1111; tx_valid = 0; tx_data = '0; rx_ready = 1;
    clear_dn();
    step(); step();
    total++;
    if ({tx_ready, upv, up_all, rx_valid, rx_data, drop_cnt, misroute_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: tx_ready=%b upv=%b up=%h rxv=%b rx=%h drop=%0d mis=%0d, required all 0",
               tx_ready, upv, up_all, rx_valid, rx_data, drop_cnt, misroute_cnt);
    end
    reset = 1;
    step();
    total++;
    if (tx_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b, required 1", tx_ready);
    end
  endtask

  task automatic test_tx_all();
    logic [63:0] exp_all;
    logic [3:0]  exp_v;
    spine_en = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        tx_valid = 1; tx_data = 16'(16'h1801 + c);
        total++;
        if (tx_ready !== 1'b1) begin
          bad++; $display("FAIL tx_all_ready[%0d]: got %b, required 1", c, tx_ready);
        end
      end else begin
        tx_valid = 0;
      end
      step();
      exp_v = '0; exp_all = '0;
      if (c >= 1 && c <= 8) begin
        exp_v   = 4'(1 << ((c - 1) % 4));
        exp_all = 64'(16'(16'h1801 + c - 1)) << (16 * ((c - 1) % 4));
      end
      total++;
      if (upv !== exp_v || up_all !== exp_all) begin
        bad++;
        $display("FAIL tx_all_issue[%0d]: upv=%b up=%h, required upv=%b up=%h", c, upv, up_all, exp_v, exp_all);
      end
    end
  endtask

  task automatic test_tx_mask();
    logic [63:0] exp_all;
    logic [3:0]  exp_v;
    int          idx;
    spine_en = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin tx_valid = 1; tx_data = 16'(16'h1901 + c); end
      else tx_valid = 0;
      step();
      exp_v = '0; exp_all = '0;
      if (c >= 1 && c <= 4) begin
        idx     = ((c - 1) % 2 == 0) ? 0 : 2;
        exp_v   = 4'(1 << idx);
        exp_all = 64'(16'(16'h1901 + c - 1)) << (16 * idx);
      end
      total++;
      if (upv !== exp_v || up_all !== exp_all) begin
        bad++;
        $display("FAIL tx_mask_issue[%0d]: upv=%b up=%h, required upv=%b up=%h", c, upv, up_all, exp_v, exp_all);
      end
    end
  endtask

  task automatic test_tx_stall();
    logic [63:0] exp_all;
    logic [3:0]  exp_v;
    int          idx;
    spine_en = 4'b0000;
    for (int c = 0; c < 9; c++) begin
      tx_valid = 1;
      tx_data  = (c < 8) ? 16'(16'h2001 + c) : 16'hDEAD;
      step();
      total++;
      if (upv !== 4'b0000) begin
        bad++; $display("FAIL stall_no_valid[%0d]: upv=%b, required 0000", c, upv);
      end
      if (c >= 7) begin
        total++;
        if (tx_ready !== 1'b0) begin
          bad++; $display("FAIL stall_full_ready[%0d]: got %b, required 0", c, tx_ready);
        end
      end
    end
    tx_valid = 0;
    spine_en = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      step();
      exp_v = '0; exp_all = '0;
      if (c < 8) begin
        idx     = (3 + c) % 4;
        exp_v   = 4'(1 << idx);
        exp_all = 64'(16'(16'h2001 + c)) << (16 * idx);
      end
      total++;
      if (upv !== exp_v || up_all !== exp_all) begin
        bad++;
        $display("FAIL stall_drain[%0d]: upv=%b up=%h, required upv=%b up=%h", c, upv, up_all, exp_v, exp_all);
      end
      if (c == 0) begin
        total++;
        if (tx_ready !== 1'b1) begin
          bad++; $display("FAIL stall_ready_back: got %b, required 1", tx_ready);
        end
      end
    end
  endtask

  task automatic test_rx_merge();
    rx_ready = 1;
    dn1_valid = 1; dn1_data = 16'h6001;
    dn2_valid = 1; dn2_data = 16'h6002;
    dn3_valid = 1; dn3_data = 16'h6003;
    dn4_valid = 1; dn4_data = 16'h6004;
    step();
    clear_dn();
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL rx_merge_latency: rx_valid=%b, required 0", rx_valid);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (c < 4) begin
        if (rx_valid !== 1'b1 || rx_data !== 16'(16'h6001 + c)) begin
          bad++; $display("FAIL rx_merge_seq[%0d]: v=%b d=%h, required v=1 d=%h", c, rx_valid, rx_data, 16'(16'h6001 + c));
        end
      end else if (rx_valid !== 1'b0) begin
        bad++; $display("FAIL rx_merge_end: v=%b, required 0", rx_valid);
      end
    end
    total++;
    if (drop_cnt !== 8'd0 || misroute_cnt !== 8'd0) begin
      bad++; $display("FAIL rx_merge_counters: drop=%0d mis=%0d, required 0 0", drop_cnt, misroute_cnt);
    end
  endtask

  task automatic test_misroute();
    dn2_valid = 1; dn2_data = 16'h7000;
    dn3_valid = 1; dn3_data = 16'h6400;
    step();
    clear_dn();
    total++;
    if (misroute_cnt !== 8'd2) begin
      bad++; $display("FAIL misroute_count: got %0d, required 2", misroute_cnt);
    end
    step(); step();
    total++;
    if (rx_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      bad++; $display("FAIL misroute_nothing: rx_valid=%b drop=%0d, required 0 0", rx_valid, drop_cnt);
    end
  endtask

  task automatic test_rx_overflow();
    rx_ready = 0;
    for (int c = 0; c < 7; c++) begin
      dn1_valid = 1; dn1_data = 16'(16'h6010 + c);
      step();
    end
    clear_dn();
    step();
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 16'h6010 || drop_cnt !== 8'd2) begin
      bad++; $display("FAIL overflow_state: v=%b d=%h drop=%0d, required v=1 d=6010 drop=2", rx_valid, rx_data, drop_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (rx_valid !== 1'b1 || rx_data !== 16'h6010) begin
        bad++; $display("FAIL overflow_hold[%0d]: v=%b d=%h, required v=1 d=6010", c, rx_valid, rx_data);
      end
    end
    rx_ready = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (c < 4) begin
        if (rx_valid !== 1'b1 || rx_data !== 16'(16'h6011 + c)) begin
          bad++; $display("FAIL overflow_drain[%0d]: v=%b d=%h, required v=1 d=%h", c, rx_valid, rx_data, 16'(16'h6011 + c));
        end
      end else if (rx_valid !== 1'b0) begin
        bad++; $display("FAIL overflow_drain_end: v=%b, required 0", rx_valid);
      end
    end
  endtask

  task automatic test_saturation();
    dn1_valid = 1; dn2_valid = 1; dn3_valid = 1; dn4_valid = 1;
    dn1_data = 16'h7000; dn2_data = 16'h7000; dn3_data = 16'h7000; dn4_data = 16'h7000;
    for (int c = 0; c < 75; c++) begin
      step();
      if (c == 62) begin
        total++;
        if (misroute_cnt !== 8'd254) begin
          bad++; $display("FAIL sat_before: got %0d, required 254", misroute_cnt);
        end
      end
    end
    clear_dn();
    step();
    total++;
    if (misroute_cnt !== 8'd255 || drop_cnt !== 8'd2) begin
      bad++; $display("FAIL sat_final: mis=%0d drop=%0d, required 255 2", misroute_cnt, drop_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    rx_ready = 0; spine_en = 4'b0000;
    tx_valid = 1; tx_data = 16'h3001;
    dn1_valid = 1; dn1_data = 16'h6101; dn2_valid = 1; dn2_data = 16'h6201;
    step();
    tx_data = 16'h3002; dn1_data = 16'h6102; dn2_data = 16'h6202;
    step();
    tx_data = 16'h3003; dn1_data = 16'h6103; dn2_valid = 0;
    step();
    tx_valid = 0; clear_dn();
    spine_en = 4'b1111;
    step();
    total++;
    if (upv !== 4'b1000 || up4_data !== 16'h3001) begin
      bad++; $display("FAIL mid_pre_up4: upv=%b d=%h, required 1000 3001", upv, up4_data);
    end
    step();
    total++;
    if (upv !== 4'b0001 || up1_data !== 16'h3002 || rx_valid !== 1'b1 || rx_data !== 16'h6201) begin
      bad++; $display("FAIL mid_pre_state: upv=%b up1=%h rxv=%b rx=%h, required 0001 3002 1 6201", upv, up1_data, rx_valid, rx_data);
    end
    #2 reset = 0;
    #1;
    total++;
    if ({tx_ready, upv, up_all, rx_valid, rx_data, drop_cnt, misroute_cnt} !== '0) begin
      bad++;
      $display("FAIL mid_async_clear: tx_ready=%b upv=%b up=%h rxv=%b rx=%h drop=%0d mis=%0d, required all 0",
               tx_ready, upv, up_all, rx_valid, rx_data, drop_cnt, misroute_cnt);
    end
    step();
    reset = 1;
    rx_ready = 1;
    step();
    total++;
    if (tx_ready !== 1'b1 || upv !== 4'b0000 || rx_valid !== 1'b0) begin
      bad++; $display("FAIL mid_release: ready=%b upv=%b rxv=%b, required 1 0000 0", tx_ready, upv, rx_valid);
    end
    step();
    total++;
    if (upv !== 4'b0000 || rx_valid !== 1'b0) begin
      bad++; $display("FAIL mid_no_stale: upv=%b rxv=%b, required 0000 0", upv, rx_valid);
    end
    tx_valid = 1; tx_data = 16'h3100;
    dn2_valid = 1; dn2_data = 16'h6022; dn3_valid = 1; dn3_data = 16'h6033;
    step();
    tx_valid = 0; clear_dn();
    step();
    total++;
    if (upv !== 4'b0001 || up1_data !== 16'h3100 || rx_valid !== 1'b1 || rx_data !== 16'h6022) begin
      bad++; $display("FAIL mid_ptr_restart: upv=%b up1=%h rxv=%b rx=%h, required 0001 3100 1 6022", upv, up1_data, rx_valid, rx_data);
    end
    step();
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 16'h6033 || upv !== 4'b0000) begin
      bad++; $display("FAIL mid_second: rxv=%b rx=%h upv=%b, required 1 6033 0000", rx_valid, rx_data, upv);
    end
    step();
    total++;
    if (rx_valid !== 1'b0 || drop_cnt !== 8'd0 || misroute_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_end: rxv=%b drop=%0d mis=%0d, required 0 0 0", rx_valid, drop_cnt, misroute_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_tx_all();
    test_tx_mask();
    test_tx_stall();
    test_rx_merge();
    test_misroute();
    test_rx_overflow();
    test_saturation();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
